// File: rtl/lsu_ctrl.sv
// lsu_ctrl: multi-cycle load/store unit between execute and writeback.
// Takes one memory operation at a time, issues a single aligned word
// request on the memory bus, then returns extended load data (or 0 for
// stores) with an error flag.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        operation handshake from execute
//   in_addr/in_wdata/in_ctrl byte address, right-aligned store data, opcode
//   out_valid/out_ready      result handshake to writeback
//   out_rdata/out_err        extended load data, error flag
//   mem_req_*                aligned word request (addr, wen, wdata, wmask)
//   mem_rsp_*                word response (valid, rdata, err)
//
// state  | meaning
// IDLE   | ready to accept an operation
// REQ    | bus request presented, waiting for mem_req_ready
// WAIT   | waiting for mem_rsp_valid (optionally bounded by TIMEOUT)
// RESP   | result presented, waiting for out_ready
module lsu_ctrl #(
    parameter int XLEN    = 64,
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [3:0]        in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_rdata,
    output logic              out_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_wen,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [XLEN/8-1:0] mem_req_wmask,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_rdata,
    input  logic              mem_rsp_err
);

    localparam int NB    = XLEN / 8;
    localparam int OFFW  = $clog2(NB);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t            r_state;
    logic [OFFW-1:0]   r_off;
    logic [1:0]        r_szlog;
    logic              r_sgn;
    logic              r_st;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_out_valid;
    logic [XLEN-1:0]   r_out_rdata;
    logic              r_out_err;
    logic              r_req_valid;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_req_wen;
    logic [XLEN-1:0]   r_req_wdata;
    logic [NB-1:0]     r_req_wmask;

    logic              w_legal;
    logic [1:0]        w_szlog;
    logic              w_sgn;
    logic              w_st;
    logic [3:0]        w_nbytes;
    logic              w_mis;
    logic [OFFW-1:0]   w_off;
    logic [NB-1:0]     w_wmask;
    logic [XLEN-1:0]   w_wdata;
    logic [ADDR_W-1:0] w_req_addr;
    logic [XLEN-1:0]   w_shifted;
    logic [6:0]        w_bits;
    logic [XLEN-1:0]   w_lo_mask;
    logic              w_sign;
    logic [XLEN-1:0]   w_ext;

    // Opcode decode: size as log2(bytes), signedness, legality.
    always_comb begin
        w_legal = 1'b0;
        w_szlog = 2'd0;
        w_sgn   = 1'b0;
        w_st    = in_ctrl[3];
        case (in_ctrl)
            4'b0000: begin w_legal = (XLEN == 64); w_szlog = 2'd3; end
            4'b0001: begin w_legal = 1'b1; w_szlog = 2'd1; end
            4'b0010: begin w_legal = 1'b1; w_szlog = 2'd0; end
            4'b0011: begin w_legal = 1'b1; w_szlog = 2'd2; w_sgn = 1'b1; end
            4'b0100: begin w_legal = 1'b1; w_szlog = 2'd1; w_sgn = 1'b1; end
            4'b0101: begin w_legal = (XLEN == 64); w_szlog = 2'd2; end
            4'b0110: begin w_legal = 1'b1; w_szlog = 2'd0; w_sgn = 1'b1; end
            4'b1000: begin w_legal = (XLEN == 64); w_szlog = 2'd3; end
            4'b1001: begin w_legal = 1'b1; w_szlog = 2'd2; end
            4'b1010: begin w_legal = 1'b1; w_szlog = 2'd1; end
            4'b1011: begin w_legal = 1'b1; w_szlog = 2'd0; end
            default: ;
        endcase
    end

    // Request path. A full-width shift wraps to 0, so (1<<n)-1 gives all ones
    // for a full-word access without a special case.
    assign w_nbytes   = 4'd1 << w_szlog;
    assign w_mis      = |(in_addr[2:0] & 3'(w_nbytes - 4'd1));
    assign w_off      = in_addr[OFFW-1:0];
    assign w_wmask    = ((NB'(1) << w_nbytes) - NB'(1)) << w_off;
    assign w_wdata    = in_wdata << {w_off, 3'b000};
    assign w_req_addr = {in_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};

    // Load path: right-align the addressed lane, then zero/sign extend.
    assign w_shifted = mem_rsp_rdata >> {r_off, 3'b000};
    assign w_bits    = 7'd8 << r_szlog;
    assign w_lo_mask = (XLEN'(1) << w_bits) - XLEN'(1);
    assign w_sign    = r_sgn & (|(w_shifted & (XLEN'(1) << (w_bits - 7'd1))));
    assign w_ext     = (w_shifted & w_lo_mask) | (w_sign ? ~w_lo_mask : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_off       <= '0;
            r_szlog     <= '0;
            r_sgn       <= 1'b0;
            r_st        <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_rdata <= '0;
            r_out_err   <= 1'b0;
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_req_wen   <= 1'b0;
            r_req_wdata <= '0;
            r_req_wmask <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_off   <= w_off;
                        r_szlog <= w_szlog;
                        r_sgn   <= w_sgn;
                        r_st    <= w_st;
                        if (!w_legal || w_mis) begin
                            r_out_valid <= 1'b1;
                            r_out_rdata <= '0;
                            r_out_err   <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            r_req_valid <= 1'b1;
                            r_req_addr  <= w_req_addr;
                            r_req_wen   <= w_st;
                            r_req_wdata <= w_wdata;
                            r_req_wmask <= w_st ? w_wmask : '0;
                            r_state     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // A response arriving in the same cycle is deliberately ignored.
                    if (mem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_rdata <= r_st ? '0 : w_ext;
                        r_out_err   <= mem_rsp_err;
                        r_state     <= S_RESP;
                    end else if (TIMEOUT > 0) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == TO_LAST) begin
                            r_out_valid <= 1'b1;
                            r_out_rdata <= '0;
                            r_out_err   <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready      = (r_state == S_IDLE) && !rst;
    assign out_valid     = r_out_valid;
    assign out_rdata     = r_out_rdata;
    assign out_err       = r_out_err;
    assign mem_req_valid = r_req_valid;
    assign mem_req_addr  = r_req_addr;
    assign mem_req_wen   = r_req_wen;
    assign mem_req_wdata = r_req_wdata;
    assign mem_req_wmask = r_req_wmask;

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Parametrised, multi-cycle load/store unit that replaces the combinational DPI memory stage.
- Accepts one memory operation at a time from the execute stage over a valid/ready handshake.
- Issues one aligned word request on a request/response memory bus, generating byte masks and lane-shifting write data.
- Shifts, zero-extends or sign-extends load data, then returns a result with an error flag to writeback over a valid/ready handshake.

Parameters:
XLEN, 64, data width in bits; legal values are 32 and 64.
ADDR_W, 64, address width in bits.
TIMEOUT, 0, maximum cycles spent waiting for a response; 0 disables the timeout.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  request from execute is valid
in_ready  out  1  unit can accept a request
in_addr  in  ADDR_W  byte address
in_wdata  in  XLEN  store data, right-aligned
in_ctrl  in  4  operation code (see Behaviour)
out_valid  out  1  result is valid
out_ready  in  1  writeback accepts the result
out_rdata  out  XLEN  extended load data; 0 for stores
out_err  out  1  misaligned access, illegal code, bus error or timeout
mem_req_valid  out  1  bus request is valid
mem_req_ready  in  1  bus accepts the request
mem_req_addr  out  ADDR_W  in_addr with the low log2(XLEN/8) bits cleared
mem_req_wen  out  1  1 = write
mem_req_wdata  out  XLEN  lane-shifted store data
mem_req_wmask  out  XLEN/8  byte enables; all zero for reads
mem_rsp_valid  in  1  response valid; the unit is always ready in WAIT
mem_rsp_rdata  in  XLEN  full-word read data
mem_rsp_err  in  1  bus error

Behaviour:
- Clock and reset: single clock `clk`; `rst` is synchronous and active-high.
- Reset: state=IDLE, timeout counter=0, all registered outputs 0. in_ready = (state==IDLE) && !rst.
- Codes (bit 3 = store):
  - 0000 LD, 0001 LHU, 0010 LBU, 0011 LW, 0100 LH, 0101 LWU, 0110 LB
  - 1000 SD, 1001 SW, 1010 SH, 1011 SB
  - Any other code is illegal. LD, LWU and SD are illegal when XLEN=32.
- Size and alignment: size = 1, 2, 4 or 8 bytes; off = in_addr mod (XLEN/8). The access is misaligned if in_addr mod size != 0.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - On in_valid && in_ready, latch addr, wdata and ctrl.
  - Illegal or misaligned request: go to RESP with err=1 and rdata=0; no bus activity.
  - Otherwise go to REQ.
- REQ:
  - mem_req_valid=1; all mem_req_* fields are registered and held stable until mem_req_ready.
  - wmask = ((1<<size)-1) << off.
  - wdata = in_wdata << (8*off); bytes outside the mask are don't-care but driven deterministically.
  - On mem_req_ready: go to WAIT and clear the counter.
- WAIT:
  - mem_rsp_valid: capture shifted = mem_rsp_rdata >> (8*off).
    - Zero-extend or sign-extend from bit 8*size-1 according to the code.
    - err = mem_rsp_err.
    - Stores set rdata=0.
    - Go to RESP.
  - With TIMEOUT>0 and no response: increment the counter each cycle. When it reaches TIMEOUT, go to RESP with err=1 and rdata=0.
- RESP: out_valid=1, and out_rdata/out_err are held stable until out_ready. On handshake, go to IDLE.
  - in_ready rises the following cycle; there is no bypass from RESP to accept.
- Minimum latency:
  - Legal request accepted at cycle T: mem_req_valid at T+1; with mem_req_ready=1 and mem_rsp_valid=1 at T+2, out_valid at T+3.
  - Illegal or misaligned request: out_valid at T+1.
- Ignored inputs: mem_rsp_valid outside WAIT is ignored, including a late response after a timeout. A simultaneous mem_req_ready and mem_rsp_valid in REQ counts only the request.
- rst in any state: IDLE next cycle, and every valid output is deasserted that cycle. An outstanding bus transaction is abandoned.

Test Plan:
- XLEN=64, LB at addr 0x1003, rsp rdata 0x00000000_80000000 -> out_rdata 0xFFFFFFFF_FFFFFF80, out_err=0; LBU at the same address -> 0x80.
- SH at 0x2006, wdata 0x1234 -> mem_req_addr 0x2000, wmask 0xC0, wdata[63:48]=0x1234, wen=1; response -> out_rdata 0.
- LW at 0x3002 -> no mem_req_valid; out_valid at T+1 with out_err=1; code 0111 behaves the same.
- mem_req_ready held low for 5 cycles -> mem_req_addr, wdata and wmask constant throughout; out_ready low for 3 cycles -> out_rdata held and in_ready=0.
- TIMEOUT=4, no response -> out_err=1 exactly 4 cycles after entering WAIT; a later mem_rsp_valid is ignored and the next load completes normally.
- rst asserted while in WAIT -> next cycle IDLE with all outputs 0; in_ready=1 once rst deasserts. XLEN=32 LD -> out_err=1.
